// File: rtl/tt_sweep_capture.sv
// Truth-table sweeper: drives all 16 input vectors to a 4-input combinational unit,
// holds each for HOLD_CYCLES, and records its f/g responses against expected maps.
module tt_sweep_capture #(
    parameter int unsigned HOLD_CYCLES = 20,
    parameter logic [15:0] EXP_F       = 16'h0000,
    parameter logic [15:0] EXP_G       = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        f,
    input  logic        g,
    output logic [3:0]  vec_idx,
    output logic        busy,
    output logic        done,
    output logic [15:0] f_map,
    output logic [15:0] g_map,
    output logic [4:0]  err_count,
    output logic        pass
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  vec_idx_q, vec_idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] f_map_q, f_map_d;
    logic [15:0] g_map_q, g_map_d;
    logic [4:0]  err_count_q, err_count_d;
    logic        pass_q, pass_d;
    logic        mismatch_s;

    // One vector counts once even when both f and g disagree.
    assign mismatch_s = (f != EXP_F[vec_idx_q]) || (g != EXP_G[vec_idx_q]);

    // Next-state and next-output logic for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d     = state_q;
        vec_idx_d   = vec_idx_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        f_map_d     = f_map_q;
        g_map_d     = g_map_q;
        err_count_d = err_count_q;
        pass_d      = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    vec_idx_d   = 4'd0;
                    cnt_d       = 8'd0;
                    busy_d      = 1'b1;
                    f_map_d     = 16'h0000;
                    g_map_d     = 16'h0000;
                    err_count_d = 5'd0;
                    pass_d      = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q == LAST_CNT) begin
                    f_map_d[vec_idx_q] = f;
                    g_map_d[vec_idx_q] = g;
                    err_count_d        = err_count_q + {4'd0, mismatch_s};
                    cnt_d              = 8'd0;
                    if (vec_idx_q == 4'd15) begin
                        state_d   = ST_DONE;
                        vec_idx_d = 4'd0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        pass_d    = (err_count_d == 5'd0);
                    end else begin
                        vec_idx_d = vec_idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                vec_idx_d = 4'd0;
                cnt_d     = 8'd0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset overrides any sweep in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vec_idx_q   <= 4'd0;
            cnt_q       <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            f_map_q     <= 16'h0000;
            g_map_q     <= 16'h0000;
            err_count_q <= 5'd0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_idx_q   <= vec_idx_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            f_map_q     <= f_map_d;
            g_map_q     <= g_map_d;
            err_count_q <= err_count_d;
            pass_q      <= pass_d;
        end
    end

    assign {a, b, c, d} = vec_idx_q;
    assign vec_idx      = vec_idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign f_map        = f_map_q;
    assign g_map        = g_map_q;
    assign err_count    = err_count_q;
    assign pass         = pass_q;

endmodule

// File: doc/tt_sweep_capture.md
TT_SWEEP_CAPTURE -- requirements
Module: tt_sweep_capture

Interface
REQ-001 SHALL provide parameter HOLD_CYCLES, default 20, cycles each input vector is held (legal range 2..255).
REQ-002 SHALL provide parameter EXP_F, default 16'h0000, expected f per vector (bit i = vector i).
REQ-003 SHALL provide parameter EXP_G, default 16'h0000, expected g per vector (bit i = vector i).
REQ-004 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have start  input  1  sweep request, sampled only in IDLE.
REQ-007 SHALL have a, b, c, d  output  1 each  drive to the combinational unit under sweep; {a,b,c,d} = vec_idx, a is MSB.
REQ-008 SHALL have f, g  input  1 each  responses of the unit under sweep.
REQ-009 SHALL have vec_idx  output  4  current vector index.
REQ-010 SHALL have busy  output  1  high while sweeping.
REQ-011 SHALL have done  output  1  one-cycle pulse at sweep end.
REQ-012 SHALL have f_map, g_map  output  16 each  captured f/g; bit i = response to vector i.
REQ-013 SHALL have err_count  output  5  count of vectors where f or g differs from EXP_F/EXP_G (0..16).
REQ-014 SHALL have pass  output  1  high after a completed sweep with err_count == 0.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-016 IDLE: start=1 at an edge -> RUN; vec_idx=0, hold counter=0, f_map/g_map/err_count/pass cleared at that same edge.
REQ-017 IDLE with start=0 SHALL hold all outputs unchanged (captured maps retained).
REQ-018 RUN: busy=1; hold counter increments each cycle 0..HOLD_CYCLES-1; each vector held exactly HOLD_CYCLES cycles.
REQ-019 At the edge where counter==HOLD_CYCLES-1, f/g SHALL be captured into f_map[vec_idx]/g_map[vec_idx], and err_count SHALL increment by 1 if (f!=EXP_F[vec_idx]) or (g!=EXP_G[vec_idx]); never by 2 for one vector.
REQ-020 Same edge: if vec_idx<15, vec_idx+1 and counter=0; if vec_idx==15, -> DONE.
REQ-021 vec_idx SHALL NOT wrap to 0 inside RUN; exactly 16 vectors, total RUN length 16*HOLD_CYCLES cycles.
REQ-022 DONE: lasts exactly one cycle; done=1, busy=0, {a,b,c,d}=0000, vec_idx=0; pass=1 iff final err_count==0; then -> IDLE.
REQ-023 start asserted in RUN or DONE SHALL be ignored (no restart, no clearing).
REQ-024 start held high continuously SHALL begin a new sweep from IDLE the edge after DONE.
REQ-025 err_count arithmetic SHALL be 5-bit unsigned, saturating impossible by construction (max 16).

Reset
REQ-026 rst=1 at any edge SHALL force IDLE, vec_idx=0, {a,b,c,d}=0000, counter=0, busy=0, done=0, f_map=0, g_map=0, err_count=0, pass=0.
REQ-027 rst SHALL take priority over start and over any RUN/DONE activity, including mid-sweep (no partial done pulse).
REQ-028 After rst deasserts, block SHALL stay in IDLE until start is sampled.

Verification
REQ-029 HOLD_CYCLES=4, f tied to a&b, g tied to c|d, EXP_F=16'hF000, EXP_G=16'hEEEE; pulse start -> busy high 64 cycles, done pulse next cycle, f_map=16'hF000, g_map=16'hEEEE, err_count=0, pass=1.
REQ-030 Same setup but EXP_F=16'hF001 -> err_count=1, pass=0, f_map=16'hF000.
REQ-031 HOLD_CYCLES=20: each {a,b,c,d} value stable exactly 20 cycles, sequence 0000..1111 in order, a MSB.
REQ-032 Assert rst at cycle 30 of a sweep -> next cycle busy=0, maps=0, err_count=0, no done pulse; new start sweeps from vector 0.
REQ-033 Pulse start at cycles 10 and 40 of a running sweep -> ignored; single done pulse at 16*HOLD_CYCLES cycles.
REQ-034 Hold start=1 permanently -> back-to-back sweeps, one IDLE cycle between done and next busy, maps cleared at each restart.
